// File: rtl/bxu_data_unit.sv
// BXU data-operation unit: NOP/MOD/SET/GET/PUT on the current cell under a valid/ready command handshake.
// Define BXU_DATA_SAT_EN to make MOD saturate instead of wrapping.
module bxu_data_unit #(
  parameter int DATA_BITWIDTH = 8,
  parameter int CODE_BITWIDTH = 16,
  parameter int IMM_BITWIDTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [2:0]               op,
  input  logic [CODE_BITWIDTH-1:0] code,
  input  logic [DATA_BITWIDTH-1:0] data,
  input  logic                     abort,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_BITWIDTH-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_BITWIDTH-1:0] data_out,
  output logic                     data_wr,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, GET_WAIT, PUT_WAIT, FIN} state_t;

  localparam logic [2:0] OP_MOD = 3'd1;
  localparam logic [2:0] OP_SET = 3'd2;
  localparam logic [2:0] OP_GET = 3'd3;
  localparam logic [2:0] OP_PUT = 3'd4;

  state_t                   r_state, w_state_next;
  logic [DATA_BITWIDTH-1:0] r_data_out, w_data_out_next;
  logic [DATA_BITWIDTH-1:0] r_out_data, w_out_data_next;
  logic                     r_wr_pend, w_wr_pend_next;

  logic [DATA_BITWIDTH-1:0] w_imm;
  logic                     w_pn;
  logic                     w_mem;
  logic [DATA_BITWIDTH:0]   w_sum;
  logic [DATA_BITWIDTH:0]   w_diff;
  logic [DATA_BITWIDTH-1:0] w_mod_result;
  logic                     w_accept;
  logic                     w_unused;

  assign w_pn     = code[CODE_BITWIDTH-1];
  assign w_mem    = code[CODE_BITWIDTH-3];
  assign w_unused = ^code;
  assign w_accept = op_valid && (r_state == IDLE);

  always_comb begin
    w_imm = '0;
    w_imm[IMM_BITWIDTH-1:0] = code[IMM_BITWIDTH+3:4];
  end

  // One extra bit catches carry-out on add and borrow on subtract.
  assign w_sum  = {1'b0, data} + {1'b0, w_imm};
  assign w_diff = {1'b0, data} - {1'b0, w_imm};

  always_comb begin
`ifdef BXU_DATA_SAT_EN
    if (w_pn)
      w_mod_result = w_diff[DATA_BITWIDTH] ? '0 : w_diff[DATA_BITWIDTH-1:0];
    else
      w_mod_result = w_sum[DATA_BITWIDTH] ? '1 : w_sum[DATA_BITWIDTH-1:0];
`else
    w_mod_result = w_pn ? w_diff[DATA_BITWIDTH-1:0] : w_sum[DATA_BITWIDTH-1:0];
`endif
  end

  always_comb begin
    w_state_next    = r_state;
    w_data_out_next = r_data_out;
    w_out_data_next = r_out_data;
    w_wr_pend_next  = r_wr_pend;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (op)
            OP_MOD: begin
              w_data_out_next = w_mod_result;
              w_wr_pend_next  = 1'b1;
              w_state_next    = FIN;
            end
            OP_SET: begin
              w_data_out_next = w_mem ? data : w_imm;
              w_wr_pend_next  = 1'b1;
              w_state_next    = FIN;
            end
            OP_GET: w_state_next = GET_WAIT;
            OP_PUT: begin
              w_out_data_next = data;
              w_state_next    = PUT_WAIT;
            end
            default: begin
              w_wr_pend_next = 1'b0;
              w_state_next   = FIN;
            end
          endcase
        end
      end
      GET_WAIT: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (in_valid) begin
          w_data_out_next = in_data;
          w_wr_pend_next  = 1'b1;
          w_state_next    = FIN;
        end
      end
      // Abort takes priority over a simultaneous out_ready.
      PUT_WAIT: begin
        if (abort) begin
          w_state_next = IDLE;
        end else if (out_ready) begin
          w_wr_pend_next = 1'b0;
          w_state_next   = FIN;
        end
      end
      FIN:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_data_out <= '0;
      r_out_data <= '0;
      r_wr_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data_out <= w_data_out_next;
      r_out_data <= w_out_data_next;
      r_wr_pend  <= w_wr_pend_next;
    end
  end

  assign op_ready  = (r_state == IDLE);
  assign in_ready  = (r_state == GET_WAIT) && !abort;
  assign out_valid = (r_state == PUT_WAIT);
  assign done      = (r_state == FIN);
  assign data_wr   = (r_state == FIN) && r_wr_pend;
  assign data_out  = r_data_out;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_bxu_data_unit.sv
// Directed self-checking bench for bxu_data_unit; expected values are hand-computed per step.
module tb_bxu_data_unit;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op;
  logic [15:0] code;
  logic [7:0]  data;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  data_out;
  logic        data_wr;
  logic        done;

  int checks   = 0;
  int failures = 0;
  int inReadyCount;

  bxu_data_unit #(.DATA_BITWIDTH(8), .CODE_BITWIDTH(16), .IMM_BITWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .code(code), .data(data), .abort(abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .data_wr(data_wr), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command just before a rising edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [2:0] opc, input logic [15:0] cw, input logic [7:0] d);
    @(negedge clk);
    op_valid = 1'b1;
    op       = opc;
    code     = cw;
    data     = d;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op = 3'd0; code = '0; data = '0;
    abort = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_op_ready", op_ready, 1);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_strobes", {data_wr, done, in_ready, out_valid}, 0);
    rst_n = 1'b1;

    // Modify op, add 0x10 + 0x05
    applyStimulus(3'd1, 16'h0050, 8'h10);
    @(negedge clk);
    checkOutput("mod_add_data_out", data_out, 8'h15);
    checkOutput("mod_add_fin", {data_wr, done, op_ready}, 3'b110);
    @(negedge clk);
    checkOutput("mod_add_after", {data_wr, done, op_ready}, 3'b001);

    // Modify op, subtract 0x05 - 0x10
    applyStimulus(3'd1, 16'h8100, 8'h05);
    @(negedge clk);
`ifdef BXU_DATA_SAT_EN
    checkOutput("mod_sub_data_out", data_out, 8'h00);
`else
    checkOutput("mod_sub_data_out", data_out, 8'hF5);
`endif
    checkOutput("mod_sub_wr", {data_wr, done}, 2'b11);

    // Modify op, add overflow 0xF0 + 0x20
    applyStimulus(3'd1, 16'h0200, 8'hF0);
    @(negedge clk);
`ifdef BXU_DATA_SAT_EN
    checkOutput("mod_ovf_data_out", data_out, 8'hFF);
`else
    checkOutput("mod_ovf_data_out", data_out, 8'h10);
`endif

    // SET immediate and SET from cell
    applyStimulus(3'd2, 16'h0A50, 8'h33);
    @(negedge clk);
    checkOutput("set_imm_data_out", data_out, 8'hA5);
    checkOutput("set_imm_wr", {data_wr, done}, 2'b11);
    applyStimulus(3'd2, 16'h2A50, 8'h5A);
    @(negedge clk);
    checkOutput("set_mem_data_out", data_out, 8'h5A);

    // GET with 4 idle cycles, transfer on the 5th
    applyStimulus(3'd3, 16'h0000, 8'h00);
    inReadyCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (in_ready) inReadyCount++;
      checkOutput("get_wait_done", {done, data_wr, op_ready}, 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    if (in_ready) inReadyCount++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    checkOutput("get_in_ready_cycles", inReadyCount, 5);
    @(negedge clk);
    checkOutput("get_data_out", data_out, 8'h3C);
    checkOutput("get_fin", {data_wr, done, in_ready}, 3'b110);
    @(negedge clk);
    checkOutput("get_after", {data_wr, done, op_ready}, 3'b001);

    // PUT with out_ready low for 3 cycles
    applyStimulus(3'd4, 16'h0000, 8'h7E);
    data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("put_wait_valid", {out_valid, done, op_ready}, 3'b100);
      checkOutput("put_wait_data", out_data, 8'h7E);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("put_hs_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("put_fin", {done, data_wr, out_valid}, 3'b100);
    checkOutput("put_data_out_kept", data_out, 8'h3C);

    // GET aborted while in_valid is also high
    applyStimulus(3'd3, 16'h0000, 8'h00);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h99;
    @(negedge clk);
    checkOutput("get_abort_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("get_abort_idle", {op_ready, done, data_wr}, 3'b100);
    checkOutput("get_abort_data_out", data_out, 8'h3C);

    // PUT with abort and out_ready together
    applyStimulus(3'd4, 16'h0000, 8'h11);
    abort     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("put_abort_idle", {op_ready, done, out_valid}, 3'b100);
    checkOutput("put_abort_out_data", out_data, 8'h11);

    // Reset mid PUT_WAIT
    applyStimulus(3'd4, 16'h0000, 8'h44);
    @(negedge clk);
    checkOutput("put_rst_pre_valid", out_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("put_rst_outputs", {out_valid, done, data_wr, in_ready, op_ready}, 5'b00001);
    checkOutput("put_rst_data", {data_out, out_data}, 16'h0000);
    #1 rst_n = 1'b1;

    // NOP and reserved opcode after reset
    applyStimulus(3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    checkOutput("nop_fin", {done, data_wr}, 2'b10);
    applyStimulus(3'd7, 16'h0A50, 8'h22);
    @(negedge clk);
    checkOutput("rsv_fin", {done, data_wr}, 2'b10);
    checkOutput("rsv_data_out", data_out, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
